// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// Drives one NAND-gate full-adder cell over WIDTH cycles, LSB first, with the
// carry recirculated through a flip-flop. Result and carry-out are published
// only on the completion edge and held until the next completion or reset.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.

// One-bit full adder built purely from two-input NAND gates.
module serial_add_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  logic n1, n2, n3, x, n4, n5, n6;

  assign n1   = ~(a_i & b_i);
  assign n2   = ~(a_i & n1);
  assign n3   = ~(b_i & n1);
  assign x    = ~(n2 & n3);     // a ^ b
  assign n4   = ~(x & c_i);
  assign n5   = ~(x & n4);
  assign n6   = ~(c_i & n4);
  assign s_o  = ~(n5 & n6);     // a ^ b ^ c
  assign co_o = ~(n1 & n4);     // a&b | (a^b)&c
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] acc_shifted;

  // The shared full-adder slice always sees the current LSBs and carry.
  serial_add_fa_cell u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_sum),
    .co_o (fa_cout)
  );

  // Accumulator after absorbing this cycle's sum bit at the MSB end; written
  // as shifts so that WIDTH=1 needs no zero-width slice.
  assign acc_shifted = (acc_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        acc_d   = acc_shifted;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          sum_d   = acc_shifted;
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          // While the last bit is processed, carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop sees
    // the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): directed scenarios plus random
// operations checked against an arithmetic reference model.
// Honours SERIAL_ADD_OVF_EN the same way as the design.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cin_in;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Held results the DUT should be showing.
  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf  = 1'b0;

  int cyc       = 0;
  int last_done = 0;
  int done_gap  = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .cin   (cin_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Mid-cycle monitor: busy/done exclusivity and spacing between done pulses.
  always @(negedge clk) begin
    if (rst === 1'b0) check("busy_done_excl", {62'd0, busy, done} == 64'd3, 64'd0);
    if (done === 1'b1) begin
      done_gap  = cyc - last_done;
      last_done = cyc;
    end
  end

  // Reference model: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    int full, sx, sy, ss;
    logic [W-1:0] s;
    logic co, ov;
    full = int'(x) + int'(y) + int'(c);
    co   = (full >= (1 << W));
    s    = W'(full % (1 << W));
    sx   = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy   = y[W-1] ? int'(y) - (1 << W) : int'(y);
    ss   = sx + sy + int'(c);
    ov   = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
    return {ov, co, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
  endtask

  // Present operands with start for one accepting edge (from IDLE or DONE).
  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    start  = 1'b1;
    a_in   = x;
    b_in   = y;
    cin_in = c;
    step();
  endtask

  // Called just after the accepting edge: walks the W RUN cycles, optionally
  // poking start (with a=AA) at RUN index poke, then checks the done cycle.
  task automatic run_body(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input bit hold, input int poke);
    logic [W+1:0] r;
    r = ref_add(x, y, c);
    for (int i = 0; i < W; i++) begin
      check("run_busy", 64'(busy), 64'd1);
      check("run_done", 64'(done), 64'd0);
      if (i == 3) check_held("run_hold");
      start  = hold || (i == poke);
      a_in   = (i == poke) ? 8'hAA : W'($urandom);
      b_in   = W'($urandom);
      cin_in = 1'($urandom);
      step();
    end
    exp_sum  = r[W-1:0];
    exp_cout = r[W];
    exp_ovf  = r[W+1];
    check("done_pulse", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check_held("result");
  endtask

  task automatic idle_step();
    start = 1'b0;
    step();
    check("idle_done", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check_held("idle_hold");
  endtask

  task automatic add_once(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    accept(x, y, c);
    run_body(x, y, c, 1'b0, -1);
    idle_step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    bit           chain;
    int           poke;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_held("rst");
    rst = 1'b0;
    step();

    // Basic, full carry chain, overflow cases.
    add_once(8'h0F, 8'h01, 1'b0);
    add_once(8'hFF, 8'h01, 1'b0);
    add_once(8'hFF, 8'hFF, 1'b1);
    add_once(8'h7F, 8'h01, 1'b0);
    add_once(8'h80, 8'h80, 1'b0);

    // Start pulsed during RUN (third RUN cycle) is ignored.
    accept(8'h03, 8'h04, 1'b0);
    run_body(8'h03, 8'h04, 1'b0, 1'b0, 2);
    check("ignore_sum", 64'(sum), 64'h07);
    idle_step();

    // Reset at the fourth RUN cycle aborts with no done.
    accept(8'h55, 8'h55, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check_held("abort");
    for (int i = 0; i < W + 2; i++) begin
      step();
      check("abort_no_done", 64'(done), 64'd0);
    end
    add_once(8'h10, 8'h20, 1'b0);
    check("post_abort_sum", 64'(sum), 64'h30);

    // Back-to-back with start held high.
    accept(8'h01, 8'h01, 1'b0);
    run_body(8'h01, 8'h01, 1'b0, 1'b1, -1);
    check("b2b_first", 64'(sum), 64'h02);
    accept(8'h02, 8'h02, 1'b0);
    check("b2b_rerun_busy", 64'(busy), 64'd1);
    run_body(8'h02, 8'h02, 1'b0, 1'b0, -1);
    check("b2b_second", 64'(sum), 64'h04);
    idle_step();
    check("b2b_gap", 64'(done_gap), 64'd9);

    // Random operations, randomly chained back-to-back and poked mid-RUN.
    chain = 1'b0;
    for (int k = 0; k < 30; k++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      accept(ra, rb, rc);
      chain = ($urandom_range(0, 1) == 1) && (k != 29);
      run_body(ra, rb, rc, chain, poke);
      if (!chain) idle_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell (the team's NAND-gate full adder) over WIDTH cycles to add two WIDTH-bit operands. It latches operands on a start request, feeds one bit pair per cycle LSB-first through the cell, and recirculates the carry through a flip-flop. It assembles the result and reports completion with a one-cycle done pulse. It sits between a register-file or bus front end and the single shared full-adder slice, and trades area for latency.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 1..64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an addition; sampled only when the block can accept.
- a  in  WIDTH  operand A, sampled on the accepting edge only.
- b  in  WIDTH  operand B, sampled on the accepting edge only.
- cin  in  1  carry-in, sampled on the accepting edge only.
- busy  out  1  high while bits are being processed (state RUN).
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result; holds the last completed value.
- cout  out  1  carry-out of the last completed addition.
- ovf  out  1  signed overflow of the last completed addition; present only with SERIAL_ADD_OVF_EN.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing one bit per cycle.
  - DONE: result valid.
- IDLE→RUN on start=1. The edge latches a and b into shift registers and cin into the carry flip-flop, and clears the bit counter to 0.
- RUN: each edge drives the full-adder cell with a_sh[0], b_sh[0] and carry. It then:
  - shifts the cell sum into the MSB of the internal accumulator (acc <= {fa_sum, acc[WIDTH-1:1]});
  - shifts a_sh and b_sh right by one;
  - loads the cell carry into the carry flip-flop;
  - increments the counter.
- RUN→DONE on the edge that processes bit WIDTH-1. That same edge loads acc's final value into sum and the final carry into cout.
- DONE→RUN if start=1 (back-to-back operation, same latching as from IDLE); otherwise DONE→IDLE.
- Counter width is $clog2(WIDTH+1). Counter wrap is unreachable; the counter is cleared on every accept.
- start in RUN is ignored and is not queued. Operand changes in RUN have no effect.
- sum and cout change only on completion edges. They are never visible mid-shift.
- Arithmetic is modulo 2^WIDTH: {cout,sum} = a + b + cin, exactly.
- Reset, including mid-RUN, does all of the following on the next edge:
  - state→IDLE;
  - counter, shift registers, carry, acc, sum, cout and ovf→0;
  - busy=0, done=0.
  - An aborted operation never produces done.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0.
- Accepting edge E0 (state IDLE or DONE, start=1).
- busy=1 for exactly WIDTH cycles, following E0.
- done=1 for exactly one cycle, immediately after busy falls (after edge E_WIDTH). sum/cout are valid in that cycle and held afterwards.
- Latency: done is asserted WIDTH cycles after E0.
- Throughput: one addition per WIDTH+1 cycles with start held high or reasserted in the DONE cycle.
- done and busy are never high simultaneously.
- Start accepted in the DONE cycle: done stays high that cycle, then busy rises on the next cycle.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - An extra flip-flop captures the carry into bit WIDTH-1 (the carry value present while the counter equals WIDTH-1).
  - On the completion edge, ovf <= carry_into_msb XOR final carry.
  - ovf is held until the next completion or reset.
- Not defined: the ovf port and its flip-flop are absent; all other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Basic add: start with a=8'h0F, b=8'h01, cin=0 → busy high 8 cycles, then done for one cycle with sum=8'h10, cout=0, ovf=0.
- Full carry chain: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0. Also a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Overflow (macro on): a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Also a=8'h80, b=8'h80 → sum=8'h00, cout=1, ovf=1.
- Start during RUN: accept a=8'h03, b=8'h04, then at RUN cycle 3 pulse start with a=8'hAA → ignored; done after 8 cycles with sum=8'h07, cout=0.
- Reset mid-op: accept a=8'h55, b=8'h55, assert rst at RUN cycle 4 → next cycle busy=0, done=0, sum=0, cout=0, and no done follows. Then a=8'h10, b=8'h20 → sum=8'h30.
- Back-to-back: hold start=1 with a=8'h01, b=8'h01, then a=8'h02, b=8'h02 presented in the DONE cycle → done pulses 9 cycles apart, with sum=8'h02 then sum=8'h04.
